biset_regfile: RTL and testbench

Simulation-side and synthesizable BiSet responder: a bank of `NREGS` data-width registers addressed over the BiSet set interface. It accepts single-cycle read/write commands from a BiSet initiator (e.g. `BiSetDriver` in benches, a host bridge in silicon) and returns read data one clock later. It exposes register contents and per-register hardware update/strobe ports to the surrounding logic. An out-of-range access counter supports debug.

---
 rtl/biset_regfile_if.sv | 23 ++
 rtl/biset_regfile.sv | 142 ++++++++++++++
 tb/tb_biset_regfile.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/biset_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : biset_regfile_if
//  Description : BiSet set-bus bundle between an initiator and a responder.
//                setCtrl_i = {valid, write, addr}; all-zero is idle.
//                setWrite_i carries write data, setReply_o carries read data.
//  Ports       : setCtrl_i  [AW+1:0]  command from initiator
//                setWrite_i [DW-1:0]  write data from initiator
//                setReply_o [DW-1:0]  read data from responder
//  Revision    : 1.0  initial release
// ============================================================================
interface biset_regfile_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic [AW+1:0] setCtrl_i;
   logic [DW-1:0] setWrite_i;
   logic [DW-1:0] setReply_o;

   modport master (output setCtrl_i, output setWrite_i, input  setReply_o);
   modport slave  (input  setCtrl_i, input  setWrite_i, output setReply_o);
endinterface
`default_nettype wire

// File: rtl/biset_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : biset_regfile
//  Description : BiSet responder holding NREGS data-width registers. Bus
//                reads return data one edge after the command; bus writes
//                update the register and pulse a write strobe. Each register
//                also has a hardware update port (bus write wins on
//                collision). Out-of-range accesses bump a saturating counter.
//                Optional feature macro: BISET_REGFILE_LOCK_EN -- bit 0 of
//                register NREGS-1 becomes a sticky write lock for addresses
//                0..NREGS-2 (cleared only by reset).
//  Ports       : clk_i       clock, rising edge
//                rst_ni      asynchronous active-low reset
//                bus         BiSet slave modport (setCtrl_i/setWrite_i/setReply_o)
//                regs_o      current register contents
//                hwWe_i      per-register hardware update enable
//                hwData_i    per-register hardware update value
//                wrStrobe_o  one-cycle pulse after an accepted bus write
//                rdStrobe_o  one-cycle pulse after a bus read
//                errCount_o  saturating count of rejected accesses
//  Revision    : 1.0  initial release
// ============================================================================
module biset_regfile #(
   parameter int NREGS = 8,
   parameter int ERRW  = 8,
   parameter int DW    = 32,
   parameter int AW    = 8
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   biset_regfile_if.slave        bus,
   output logic [DW-1:0]         regs_o     [NREGS],
   input  wire logic [NREGS-1:0] hwWe_i,
   input  wire logic [DW-1:0]    hwData_i   [NREGS],
   output logic [NREGS-1:0]      wrStrobe_o,
   output logic [NREGS-1:0]      rdStrobe_o,
   output logic [ERRW-1:0]       errCount_o
);

   localparam logic [AW-1:0] c_last_addr = AW'(NREGS - 1);

   logic [DW-1:0]    r_regs [NREGS];
   logic [DW-1:0]    w_next [NREGS];
   logic [DW-1:0]    r_reply;
   logic [NREGS-1:0] r_wr_strobe;
   logic [NREGS-1:0] r_rd_strobe;
   logic [ERRW-1:0]  r_err;

   logic             w_valid;
   logic             w_write;
   logic [AW-1:0]    w_addr;
   logic             w_in_range;
   logic             w_locked;
   logic             w_bus_wr;
   logic             w_bus_rd;
   logic             w_err;
   logic [NREGS-1:0] w_wr_sel;
   logic [NREGS-1:0] w_rd_sel;
   logic [DW-1:0]    w_rd_data;

   assign w_valid    = bus.setCtrl_i[AW+1];
   assign w_write    = bus.setCtrl_i[AW];
   assign w_addr     = bus.setCtrl_i[AW-1:0];
   assign w_in_range = (w_addr <= c_last_addr);

`ifdef BISET_REGFILE_LOCK_EN
   assign w_locked = r_regs[NREGS-1][0];
`else
   assign w_locked = 1'b0;
`endif

   // The lock register itself stays writable so further bits can be set.
   assign w_bus_wr = w_valid & w_write & w_in_range &
                     ~(w_locked & (w_addr != c_last_addr));
   assign w_bus_rd = w_valid & ~w_write & w_in_range;
   // Any valid command that is neither an accepted write nor a read was rejected.
   assign w_err    = w_valid & ~w_bus_wr & ~w_bus_rd;

   for (genvar i = 0; i < NREGS; i++) begin : g_decode
      assign w_wr_sel[i] = w_bus_wr & (w_addr == AW'(i));
      assign w_rd_sel[i] = w_bus_rd & (w_addr == AW'(i));
      assign regs_o[i]   = r_regs[i];
   end

   // Read mux over pre-edge register values; out of range yields zero.
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (w_addr == AW'(i)) begin
            w_rd_data = r_regs[i];
         end
      end
   end

   // Next register values: bus write overrides hardware update.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         w_next[i] = r_regs[i];
         if (w_wr_sel[i]) begin
            w_next[i] = bus.setWrite_i;
         end else if (hwWe_i[i]) begin
            w_next[i] = hwData_i[i];
         end
      end
`ifdef BISET_REGFILE_LOCK_EN
      // Lock bit is sticky against every source until reset.
      w_next[NREGS-1][0] = w_next[NREGS-1][0] | r_regs[NREGS-1][0];
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_reply     <= '0;
         r_wr_strobe <= '0;
         r_rd_strobe <= '0;
         r_err       <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= w_next[i];
         end
         r_wr_strobe <= w_wr_sel;
         r_rd_strobe <= w_rd_sel;
         // Only reads touch the reply; out-of-range reads load zero.
         if (w_valid && !w_write) begin
            r_reply <= w_in_range ? w_rd_data : '0;
         end
         if (w_err && (r_err != {ERRW{1'b1}})) begin
            r_err <= r_err + 1'b1;
         end
      end
   end

   assign bus.setReply_o = r_reply;
   assign wrStrobe_o     = r_wr_strobe;
   assign rdStrobe_o     = r_rd_strobe;
   assign errCount_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_biset_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biset_regfile
//  Description : Self-checking bench for biset_regfile. Inputs change on the
//                falling edge; outputs are compared on the following falling
//                edge against a behavioural register-file model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_biset_regfile;
   localparam int NREGS = 8;
   localparam int ERRW  = 8;
   localparam int DW    = 32;
   localparam int AW    = 8;
`ifdef BISET_REGFILE_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic             clk_i  = 1'b0;
   logic             rst_ni = 1'b0;
   logic [DW-1:0]    regs_o   [NREGS];
   logic [DW-1:0]    hwData_i [NREGS];
   logic [NREGS-1:0] hwWe_i;
   logic [NREGS-1:0] wrStrobe_o;
   logic [NREGS-1:0] rdStrobe_o;
   logic [ERRW-1:0]  errCount_o;

   always #5 clk_i = ~clk_i;

   biset_regfile_if #(.DW(DW), .AW(AW)) u_bus ();

   biset_regfile #(.NREGS(NREGS), .ERRW(ERRW), .DW(DW), .AW(AW)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .bus        (u_bus.slave),
      .regs_o     (regs_o),
      .hwWe_i     (hwWe_i),
      .hwData_i   (hwData_i),
      .wrStrobe_o (wrStrobe_o),
      .rdStrobe_o (rdStrobe_o),
      .errCount_o (errCount_o)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0]    m_regs [NREGS];
   logic [DW-1:0]    m_reply;
   int               m_err;
   logic [NREGS-1:0] m_wr;
   logic [NREGS-1:0] m_rd;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_reply = '0;
      m_err   = 0;
      m_wr    = '0;
      m_rd    = '0;
   endtask

   task automatic bump_err();
      if (m_err < (2**ERRW) - 1) m_err++;
   endtask

   // One clock edge of the register file described in plain terms.
   task automatic model_edge(input logic v, input logic w, input int a, input logic [DW-1:0] d);
      logic [DW-1:0] old [NREGS];
      for (int i = 0; i < NREGS; i++) old[i] = m_regs[i];
      m_wr = '0;
      m_rd = '0;
      for (int i = 0; i < NREGS; i++) if (hwWe_i[i]) m_regs[i] = hwData_i[i];
      if (v) begin
         if (a >= NREGS) begin
            if (!w) m_reply = '0;
            bump_err();
         end else if (w) begin
            if (LOCK && old[NREGS-1][0] && a != NREGS - 1) begin
               bump_err();
            end else begin
               m_regs[a] = d;
               m_wr[a]   = 1'b1;
            end
         end else begin
            m_reply = old[a];
            m_rd[a] = 1'b1;
         end
      end
      if (LOCK && old[NREGS-1][0]) m_regs[NREGS-1][0] = 1'b1;
   endtask

   task automatic compare_all(input string where);
      check({where, ":reply"}, 64'(u_bus.setReply_o), 64'(m_reply));
      check({where, ":err"},   64'(errCount_o), 64'(m_err));
      check({where, ":wrstb"}, 64'(wrStrobe_o), 64'(m_wr));
      check({where, ":rdstb"}, 64'(rdStrobe_o), 64'(m_rd));
      for (int i = 0; i < NREGS; i++)
         check($sformatf("%s:reg%0d", where, i), 64'(regs_o[i]), 64'(m_regs[i]));
   endtask

   task automatic set_idle();
      u_bus.setCtrl_i  = '0;
      u_bus.setWrite_i = '0;
      hwWe_i           = '0;
      for (int i = 0; i < NREGS; i++) hwData_i[i] = '0;
   endtask

   // Called at a falling edge; returns at the next falling edge after checking.
   task automatic step(input string where, input logic v, input logic w, input int a,
                       input logic [DW-1:0] d, input logic [NREGS-1:0] hwe);
      u_bus.setCtrl_i  = {v, w, AW'(a)};
      u_bus.setWrite_i = d;
      hwWe_i           = hwe;
      @(posedge clk_i);
      model_edge(v, w, a, d);
      @(negedge clk_i);
      compare_all(where);
   endtask

   task automatic do_reset();
      set_idle();
      rst_ni = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      compare_all("reset");
      rst_ni = 1'b1;
   endtask

   initial begin
      set_idle();
      model_reset();
      @(negedge clk_i);
      do_reset();

      // Read every address after reset.
      for (int a = 0; a < NREGS; a++) step("rd0", 1'b1, 1'b0, a, '0, '0);

      // Back-to-back write then read of addr 3.
      step("wr3", 1'b1, 1'b1, 3, 32'hA5A5_0001, '0);
      check("wr3_val", 64'(regs_o[3]), 64'h0000_0000_A5A5_0001);
      check("wr3_stb", 64'(wrStrobe_o), 64'h08);
      step("rd3", 1'b1, 1'b0, 3, '0, '0);
      check("rd3_val", 64'(u_bus.setReply_o), 64'h0000_0000_A5A5_0001);
      check("wr3_stb_off", 64'(wrStrobe_o), 64'h00);

      // Hardware vs bus collision on addr 2, then hardware-only update.
      hwData_i[2] = 32'h11;
      step("hwbus", 1'b1, 1'b1, 2, 32'h22, 8'h04);
      check("hwbus_val", 64'(regs_o[2]), 64'h22);
      hwData_i[2] = 32'h33;
      step("hwonly", 1'b0, 1'b0, 0, '0, 8'h04);
      check("hwonly_val", 64'(regs_o[2]), 64'h33);
      set_idle();

      // Saturation of the error counter on out-of-range accesses.
      for (int k = 0; k < 300; k++)
         step("oor", 1'b1, 1'(k & 1), NREGS, $urandom, '0);
      check("err_sat", 64'(errCount_o), 64'd255);

`ifdef BISET_REGFILE_LOCK_EN
      @(negedge clk_i);
      do_reset();
      step("lock_set", 1'b1, 1'b1, NREGS - 1, 32'h1, '0);
      step("lock_wr0", 1'b1, 1'b1, 0, 32'h5, '0);
      check("lock_reg0", 64'(regs_o[0]), 64'h0);
      check("lock_err", 64'(errCount_o), 64'd1);
      step("lock_clr", 1'b1, 1'b1, NREGS - 1, 32'h0, '0);
      check("lock_bit", 64'(regs_o[NREGS-1][0]), 64'h1);
`endif

      // Randomized traffic including hardware updates and stray addresses.
      @(negedge clk_i);
      do_reset();
      for (int k = 0; k < 400; k++) begin
         logic [NREGS-1:0] hwe;
         for (int i = 0; i < NREGS; i++) hwData_i[i] = $urandom;
         hwe = NREGS'($urandom & $urandom);
         step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom & 1),
              int'($urandom_range(0, NREGS + 3)), $urandom, hwe);
      end
      set_idle();

      // Reset asserted between a read edge and the sampling negedge.
      step("pre_wr", 1'b1, 1'b1, 3, 32'hDEAD_BEEF, '0);
      step("pre_rd", 1'b1, 1'b0, 3, '0, '0);
      u_bus.setCtrl_i = {1'b1, 1'b0, AW'(3)};
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);
      compare_all("midrst");
      check("midrst_reply", 64'(u_bus.setReply_o), 64'h0);
      set_idle();
      rst_ni = 1'b1;
      step("post_rst", 1'b1, 1'b0, 3, '0, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
